// File: rtl/hub75_top.sv
// FT232H sync-FIFO receiver feeding a 64x32x4-lane, 2-bit-plane HUB75 scan engine.
// Framebuffer is four lane banks of 2048x6 sharing one scan address.
module hub75_top (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ftdi_data,
    input  logic       ftdi_rxf_n,
    input  logic       ftdi_txe_n,
    output logic       ftdi_rd_n,
    output logic       ftdi_oe_n,
    output logic       ftdi_wr_n,
    output logic       r1,
    output logic       g1,
    output logic       b1,
    output logic       r2,
    output logic       g2,
    output logic       b2,
    output logic       r3,
    output logic       g3,
    output logic       b3,
    output logic       r4,
    output logic       g4,
    output logic       b4,
    output logic       row_clk,
    output logic       row_data,
    output logic       clk_out,
    output logic       lat,
    output logic       blank
);
    typedef enum logic [1:0] {F_IDLE, F_OE, F_READ} fifo_state_t;
    typedef enum logic [1:0] {S_SHIFT, S_LATCH, S_SHOW} scan_state_t;

    fifo_state_t fifo_state_q;
    logic        oe_n_q, rd_n_q;
    logic        byte_accept;
    logic        armed_q, armed_d;
    logic [12:0] waddr_q, waddr_d;
    logic        we;
    logic        unused_txe;

    scan_state_t scan_state_q;
    logic [7:0]  sh_cnt_q;
    logic        lat_cnt_q;
    logic [8:0]  show_cnt_q;
    logic [8:0]  show_last;
    logic [4:0]  row_q;
    logic        plane_q;
    logic        clk_out_q, lat_q, blank_q, row_clk_q, row_data_q;
    logic [3:0]  col_r_q, col_g_q, col_b_q;
    logic [3:0]  cur_r, cur_g, cur_b;
    logic [10:0] raddr;

    assign unused_txe = ftdi_txe_n;

    // oe_n leads rd_n by one cycle so the bus has turned around before the first strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_state_q <= F_IDLE;
            oe_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
        end else begin
            case (fifo_state_q)
                F_IDLE: begin
                    if (!ftdi_rxf_n) begin
                        fifo_state_q <= F_OE;
                        oe_n_q       <= 1'b0;
                    end
                end
                F_OE: begin
                    if (ftdi_rxf_n) begin
                        fifo_state_q <= F_IDLE;
                        oe_n_q       <= 1'b1;
                    end else begin
                        fifo_state_q <= F_READ;
                        rd_n_q       <= 1'b0;
                    end
                end
                F_READ: begin
                    if (ftdi_rxf_n) begin
                        fifo_state_q <= F_IDLE;
                        oe_n_q       <= 1'b1;
                        rd_n_q       <= 1'b1;
                    end
                end
                default: begin
                    fifo_state_q <= F_IDLE;
                    oe_n_q       <= 1'b1;
                    rd_n_q       <= 1'b1;
                end
            endcase
        end
    end

    assign byte_accept = !rd_n_q && !ftdi_rxf_n;

    always_comb begin
        armed_d = armed_q;
        waddr_d = waddr_q;
        we      = 1'b0;
        if (byte_accept && !rst) begin
            if (ftdi_data == 8'hFF) begin
                waddr_d = 13'd0;
                armed_d = 1'b1;
            end else if (armed_q && ftdi_data[7:6] == 2'b00) begin
                we      = 1'b1;
                waddr_d = waddr_q + 13'd1;
                if (waddr_q == 13'h1FFF) begin
                    armed_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            waddr_q <= 13'd0;
        end else begin
            armed_q <= armed_d;
            waddr_q <= waddr_d;
        end
    end

    assign raddr = {row_q, sh_cnt_q[6:1]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [5:0] mem [0:2047];
            logic [5:0] rd_q;
            always_ff @(posedge clk) begin
                if (we && waddr_q[12:11] == 2'(gi)) begin
                    mem[waddr_q[10:0]] <= ftdi_data[5:0];
                end
                rd_q <= mem[raddr];
            end
            assign cur_r[gi] = plane_q ? rd_q[5] : rd_q[4];
            assign cur_g[gi] = plane_q ? rd_q[3] : rd_q[2];
            assign cur_b[gi] = plane_q ? rd_q[1] : rd_q[0];
        end
    endgenerate

    assign show_last = plane_q ? 9'd255 : 9'd127;

    // SHIFT: odd counts load column (cnt-1)/2 with clk_out low, even counts raise clk_out
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_state_q <= S_SHIFT;
            sh_cnt_q     <= 8'd0;
            lat_cnt_q    <= 1'b0;
            show_cnt_q   <= 9'd0;
            row_q        <= 5'd0;
            plane_q      <= 1'b0;
            clk_out_q    <= 1'b0;
            lat_q        <= 1'b0;
            blank_q      <= 1'b1;
            row_clk_q    <= 1'b0;
            row_data_q   <= 1'b0;
            col_r_q      <= 4'd0;
            col_g_q      <= 4'd0;
            col_b_q      <= 4'd0;
        end else begin
            case (scan_state_q)
                S_SHIFT: begin
                    sh_cnt_q <= sh_cnt_q + 8'd1;
                    if (!plane_q) begin
                        if (sh_cnt_q == 8'd0) row_data_q <= (row_q == 5'd0);
                        if (sh_cnt_q == 8'd1) row_clk_q <= 1'b1;
                        if (sh_cnt_q == 8'd2) row_clk_q <= 1'b0;
                        if (sh_cnt_q == 8'd3) row_data_q <= 1'b0;
                    end
                    if (sh_cnt_q == 8'd129) begin
                        clk_out_q    <= 1'b0;
                        lat_q        <= 1'b1;
                        lat_cnt_q    <= 1'b0;
                        scan_state_q <= S_LATCH;
                    end else if (sh_cnt_q[0]) begin
                        clk_out_q <= 1'b0;
                        col_r_q   <= cur_r;
                        col_g_q   <= cur_g;
                        col_b_q   <= cur_b;
                    end else if (sh_cnt_q != 8'd0) begin
                        clk_out_q <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (lat_cnt_q) begin
                        lat_q        <= 1'b0;
                        blank_q      <= 1'b0;
                        show_cnt_q   <= 9'd0;
                        scan_state_q <= S_SHOW;
                    end else begin
                        lat_cnt_q <= 1'b1;
                    end
                end
                S_SHOW: begin
                    if (show_cnt_q == show_last) begin
                        blank_q      <= 1'b1;
                        sh_cnt_q     <= 8'd0;
                        plane_q      <= !plane_q;
                        scan_state_q <= S_SHIFT;
                        if (plane_q) row_q <= row_q + 5'd1;
                    end else begin
                        show_cnt_q <= show_cnt_q + 9'd1;
                    end
                end
                default: begin
                    scan_state_q <= S_SHIFT;
                    sh_cnt_q     <= 8'd0;
                    blank_q      <= 1'b1;
                end
            endcase
        end
    end

    assign ftdi_rd_n = rd_n_q;
    assign ftdi_oe_n = oe_n_q;
    assign ftdi_wr_n = 1'b1;
    assign {r4, r3, r2, r1} = col_r_q;
    assign {g4, g3, g2, g1} = col_g_q;
    assign {b4, b3, b2, b1} = col_b_q;
    assign row_clk  = row_clk_q;
    assign row_data = row_data_q;
    assign clk_out  = clk_out_q;
    assign lat      = lat_q;
    assign blank    = blank_q;
endmodule

// File: tb/tb_hub75_top.sv
// Directed bench for hub75_top: FIFO handshake table, framebuffer loads observed
// through the panel outputs, and multi-row scan timing.
module tb_hub75_top;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] ftdi_data = 8'h00;
    logic       ftdi_rxf_n = 1'b1;
    logic       ftdi_txe_n = 1'b1;
    logic       ftdi_rd_n, ftdi_oe_n, ftdi_wr_n;
    logic       r1, g1, b1, r2, g2, b2, r3, g3, b3, r4, g4, b4;
    logic       row_clk, row_data, clk_out, lat, blank;
    logic [3:0] rv, gv, bv;

    assign rv = {r4, r3, r2, r1};
    assign gv = {g4, g3, g2, g1};
    assign bv = {b4, b3, b2, b1};

    hub75_top dut (
        .clk(clk), .rst(rst), .ftdi_data(ftdi_data), .ftdi_rxf_n(ftdi_rxf_n),
        .ftdi_txe_n(ftdi_txe_n), .ftdi_rd_n(ftdi_rd_n), .ftdi_oe_n(ftdi_oe_n),
        .ftdi_wr_n(ftdi_wr_n),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .r3(r3), .g3(g3), .b3(b3), .r4(r4), .g4(g4), .b4(b4),
        .row_clk(row_clk), .row_data(row_data), .clk_out(clk_out),
        .lat(lat), .blank(blank)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int wr_bad = 0;

    always @(negedge clk) if (ftdi_wr_n !== 1'b1) wr_bad++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rxf_n;
        logic [7:0] data;
        logic       oe_n;
        logic       rd_n;
    } vec_t;

    vec_t       vecs [29];
    logic [7:0] tx_q [$];
    logic [5:0] cap_pix [4][64];
    int         rise_cnt;
    int         pulse_cnt;
    logic       pulse_rd [$];
    int         blank_runs [$];

    function automatic logic [5:0] pat(input int a);
        return 6'((a * 7 + 3) & 63);
    endfunction

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("reset_outputs",
                  {ftdi_rd_n, ftdi_oe_n, ftdi_wr_n, rv, gv, bv, clk_out, lat, blank, row_clk, row_data},
                  {3'b111, 12'h000, 5'b00100});
        end
        rst = 1'b0;
        $display("reset held %0d cycles", cycles);
    endtask

    task automatic send_stream();
        int   idx;
        int   guard;
        logic rd_seen;
        idx = 0;
        guard = 0;
        @(negedge clk);
        while (idx < tx_q.size() && guard < 20000) begin
            ftdi_rxf_n = 1'b0;
            ftdi_data  = tx_q[idx];
            rd_seen    = ftdi_rd_n;
            @(negedge clk);
            if (!rd_seen) idx++;
            guard++;
        end
        ftdi_rxf_n = 1'b1;
        check("stream_done", idx, tx_q.size());
        $display("stream sent %0d bytes in %0d cycles", idx, guard);
    endtask

    task automatic scan_run(input int n);
        logic       prev_clk_out, prev_row_clk, prev_row_data, prev_blank;
        logic [11:0] prev_col;
        int         low_len, lat_len, c, p;
        prev_clk_out = 1'b0; prev_row_clk = 1'b0; prev_row_data = 1'b0; prev_blank = 1'b1;
        prev_col = 12'h000; low_len = 0; lat_len = 0;
        rise_cnt = 0; pulse_cnt = 0;
        pulse_rd.delete();
        blank_runs.delete();
        for (int l = 0; l < 4; l++)
            for (int k = 0; k < 64; k++) cap_pix[l][k] = 6'h00;
        for (int j = 1; j <= n; j++) begin
            @(posedge clk);
            #1;
            if (clk_out && !prev_clk_out) begin
                if (rise_cnt < 128) begin
                    c = rise_cnt % 64;
                    p = rise_cnt / 64;
                    for (int l = 0; l < 4; l++) begin
                        cap_pix[l][c][4 + p] = rv[l];
                        cap_pix[l][c][2 + p] = gv[l];
                        cap_pix[l][c][p]     = bv[l];
                    end
                end
                rise_cnt++;
            end
            if ({rv, gv, bv} != prev_col) check("colour_change_clk_low", clk_out, 1'b0);
            if (row_clk && !prev_row_clk) begin
                pulse_cnt++;
                pulse_rd.push_back(row_data);
                check("row_data_setup", row_data, prev_row_data);
            end
            if (prev_row_clk) check("row_clk_width", row_clk, 1'b0);
            if (lat) begin
                lat_len++;
                check("lat_blank_clkout", {blank, clk_out}, 2'b10);
            end else if (lat_len != 0) begin
                check("lat_len", lat_len, 2);
                lat_len = 0;
            end
            if (!blank) low_len++;
            else if (low_len != 0) begin
                blank_runs.push_back(low_len);
                low_len = 0;
            end
            prev_clk_out = clk_out; prev_row_clk = row_clk;
            prev_row_data = row_data; prev_blank = blank;
            prev_col = {rv, gv, bv};
        end
        $display("scan %0d cycles: %0d clk_out rises, %0d row pulses, %0d blank runs",
                 n, rise_cnt, pulse_cnt, blank_runs.size());
    endtask

    initial begin
        logic [5:0] exp8 [8];
        // {rxf_n, data, expected oe_n, expected rd_n after the edge}
        vecs[0]  = '{1'b1, 8'h00, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'hFF, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) vecs[4 + i] = '{1'b0, 8'(i + 1), 1'b0, 1'b0};
        for (int i = 10; i < 18; i++) vecs[i] = '{1'b1, 8'h00, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 8'h07, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 8'h07, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 8'h07, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 8'h08, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 8'h00, 1'b1, 1'b1};
        vecs[23] = '{1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[24] = '{1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[26] = '{1'b0, 8'h80, 1'b0, 1'b0};
        vecs[27] = '{1'b0, 8'h05, 1'b0, 1'b0};
        vecs[28] = '{1'b1, 8'h00, 1'b1, 1'b1};
        exp8 = '{6'h05, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08};

        do_reset(4);

        for (int i = 0; i < 29; i++) begin
            ftdi_rxf_n = vecs[i].rxf_n;
            ftdi_data  = vecs[i].data;
            @(posedge clk);
            #1;
            $display("vec %0d rxf_n=%0b data=%02h oe_n=%0b rd_n=%0b", i, vecs[i].rxf_n,
                     vecs[i].data, ftdi_oe_n, ftdi_rd_n);
            check($sformatf("handshake_vec%0d", i), {ftdi_oe_n, ftdi_rd_n},
                  {vecs[i].oe_n, vecs[i].rd_n});
        end

        // reset mid-transfer, then bytes without a fresh 0xFF must be discarded
        ftdi_rxf_n = 1'b0;
        ftdi_data  = 8'h11;
        @(posedge clk); #1;
        check("midrst_oe_low", {ftdi_oe_n, ftdi_rd_n}, 2'b01);
        @(posedge clk); #1;
        check("midrst_rd_low", {ftdi_oe_n, ftdi_rd_n}, 2'b00);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_strobes_high", {ftdi_oe_n, ftdi_rd_n}, 2'b11);
        @(posedge clk); #1;
        check("midrst_strobes_hold", {ftdi_oe_n, ftdi_rd_n}, 2'b11);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_restart", {ftdi_oe_n, ftdi_rd_n}, 2'b00);
        ftdi_rxf_n = 1'b1;
        @(posedge clk); #1;
        $display("mid-transfer reset sequence done");

        do_reset(4);
        scan_run(400);
        check("short_rise_cnt", rise_cnt, 128);
        for (int c = 0; c < 8; c++) check($sformatf("load1_col%0d", c), cap_pix[0][c], exp8[c]);

        tx_q.delete();
        tx_q.push_back(8'hFF);
        for (int a = 0; a < 8192; a++) tx_q.push_back({2'b00, pat(a)});
        tx_q.push_back(8'h2A);
        send_stream();
        do_reset(4);
        scan_run(400);
        check("full_rise_cnt", rise_cnt, 128);
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < 64; c++)
                check($sformatf("full_l%0d_c%0d", l, c), cap_pix[l][c], pat(l * 2048 + c));

        tx_q.delete();
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h30);
        for (int a = 1; a < 8192; a++) tx_q.push_back(8'h00);
        send_stream();
        do_reset(4);
        scan_run(33 * 648 + 1);
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < 64; c++)
                check($sformatf("single_l%0d_c%0d", l, c), cap_pix[l][c],
                      (l == 0 && c == 0) ? 6'h30 : 6'h00);
        check("rows_rise_cnt", rise_cnt, 33 * 128);
        check("row_pulse_cnt", pulse_cnt, 33);
        for (int k = 0; k < pulse_rd.size(); k++)
            check($sformatf("row_data_pulse%0d", k + 1), pulse_rd[k], (k == 0 || k == 32) ? 1'b1 : 1'b0);
        check("blank_run_cnt", blank_runs.size(), 66);
        for (int k = 0; k < blank_runs.size(); k++)
            check($sformatf("blank_run%0d", k), blank_runs[k], (k % 2) ? 256 : 128);

        check("wr_n_held_high", wr_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
